// File: rtl/mem_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_responder_if
// Description : Request/response bus between the CPU controller (master) and
//               the memory-side responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_responder
// Description : Single-outstanding memory responder. Serves a data RAM and,
//               when MMIO_EN is defined, LED/switch registers in the upper
//               half of the address space. One response pulse per request,
//               RD_LAT cycles after the accept edge (RD_LAT legal 1..7).
//               Without MMIO_EN every access goes to RAM[addr[7:0]].
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 9,
  parameter int              RAM_DEPTH = 256,
  parameter int              RD_LAT    = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_bus_responder_if.slave   bus,
  input  logic [7:0]           sw_in,
  output logic [7:0]           ledr_out
);

  localparam int IDX_W = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;         // read data captured at accept
  logic                hold_rd_q, hold_rd_d;   // pending request is a read
  logic                hold_err_q, hold_err_d; // pending request hit unmapped I/O
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          led_q, led_d;
  logic [DATA_W-1:0]   ram_q [RAM_DEPTH];

  logic                accept;
  logic [IDX_W-1:0]    idx;
  logic                io_sel;
  logic                led_hit;
  logic                sw_hit;
  logic [7:0]          sw_sync;
  logic                ram_we;
  logic                led_we;
  logic                acc_err;
  logic [DATA_W-1:0]   rd_val;

  assign accept = bus.req_valid && (state_q == S_IDLE);
  assign idx    = bus.req_addr[IDX_W-1:0];

`ifdef MMIO_EN
  logic [7:0] sw_meta_q, sw_meta_d;
  logic [7:0] sw_sync_q, sw_sync_d;

  assign io_sel  = bus.req_addr[ADDR_W-1];
  assign led_hit = (bus.req_addr == LED_ADDR);
  assign sw_hit  = (bus.req_addr == SW_ADDR);
  assign sw_sync = sw_sync_q;

  // Next value of the two-stage switch synchronizer.
  always_comb begin
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
  end

  // Switch synchronizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end
`else
  // Without the I/O space the top address bit and the switches are ignored.
  logic unused_io;
  assign unused_io = ^{sw_in, bus.req_addr[ADDR_W-1], LED_ADDR, SW_ADDR};
  assign io_sel    = 1'b0;
  assign led_hit   = 1'b0;
  assign sw_hit    = 1'b0;
  assign sw_sync   = 8'h00;
`endif

  // Address decode: selects the write target and the read value for the
  // current request address.
  always_comb begin
    ram_we  = 1'b0;
    led_we  = 1'b0;
    acc_err = 1'b0;
    rd_val  = '0;
    if (io_sel) begin
      if (led_hit) begin
        led_we      = bus.req_we;
        rd_val[7:0] = led_q;
      end else if (sw_hit) begin
        rd_val[7:0] = sw_sync;
      end else begin
        acc_err = 1'b1;
      end
    end else begin
      ram_we = bus.req_we;
      rd_val = ram_q[idx];
    end
  end

  // FSM next state, latency counter and response staging.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_rd_d   = hold_rd_q;
    hold_err_d  = hold_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    led_d       = led_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          hold_d     = rd_val;
          hold_rd_d  = !bus.req_we;
          hold_err_d = acc_err;
          if (led_we) begin
            led_d = bus.req_wdata[7:0];
          end
          if (RD_LAT == 1) begin
            state_d   = S_RESP;
            rsp_err_d = acc_err;
            if (!bus.req_we) begin
              rsp_rdata_d = rd_val;
            end
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(RD_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d   = S_RESP;
          cnt_d     = 3'd0;
          rsp_err_d = hold_err_q;
          if (hold_rd_q) begin
            rsp_rdata_d = hold_q;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers; reset abandons any pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      hold_q      <= '0;
      hold_rd_q   <= 1'b0;
      hold_err_q  <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      led_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_rd_q   <= hold_rd_d;
      hold_err_q  <= hold_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      led_q       <= led_d;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && ram_we) begin
      ram_q[idx] <= bus.req_wdata;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign ledr_out      = led_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_responder
// Description : Self-checking bench for mem_bus_responder. Two instances
//               (RD_LAT=1 and RD_LAT=4) receive the same stimulus; one is
//               selected for checking per phase. Expected responses are
//               queued at accept time and popped when rsp_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    logic [7:0]  led;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0]  sw_in = 8'h3C;
  logic [7:0]  led1, led4;
  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        tbl[16];

  mem_bus_responder_if #(.DATA_W(16), .ADDR_W(9)) bus1 ();
  mem_bus_responder_if #(.DATA_W(16), .ADDR_W(9)) bus4 ();

  assign bus1.req_valid = req_valid;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus4.req_valid = req_valid;
  assign bus4.req_we    = req_we;
  assign bus4.req_addr  = req_addr;
  assign bus4.req_wdata = req_wdata;

  mem_bus_responder #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .sw_in(sw_in), .ledr_out(led1)
  );
  mem_bus_responder #(.RD_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .sw_in(sw_in), .ledr_out(led4)
  );

  logic        s_ready, s_valid, s_err;
  logic [15:0] s_rdata;
  logic [7:0]  s_led;
  int          lat;
  assign s_ready = sel ? bus4.req_ready : bus1.req_ready;
  assign s_valid = sel ? bus4.rsp_valid : bus1.rsp_valid;
  assign s_err   = sel ? bus4.rsp_err   : bus1.rsp_err;
  assign s_rdata = sel ? bus4.rsp_rdata : bus1.rsp_rdata;
  assign s_led   = sel ? led4 : led1;
  assign lat     = sel ? 4 : 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat=%0d t=%0t): got %h, expected %h", nm, lat, $time, act, exp);
    end
  endfunction

  function automatic void setv(input int i, input logic we, input logic [8:0] a,
                               input logic [15:0] d, input logic [15:0] rd,
                               input logic e, input logic [7:0] l);
    tbl[i].we = we; tbl[i].addr = a; tbl[i].wdata = d;
    tbl[i].rdata = rd; tbl[i].err = e; tbl[i].led = l;
  endfunction

  // Scoreboard: every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && s_valid) begin
      if (sb.size() == 0) begin
        chk("stray_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", {16'h0, s_rdata}, {16'h0, mon_e.rdata});
        chk("rsp_err", {31'h0, s_err}, {31'h0, mon_e.err});
        chk("latency", cyc - mon_e.acc + 1, lat);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic we, input logic [8:0] a, input logic [15:0] d,
                       input logic [15:0] er, input logic ee, output int acc);
    int   guard;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    guard = 0;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      acc = cyc + 1;
      e.rdata = er; e.err = ee; e.acc = acc;
      sb.push_back(e);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int acc, prev, stray;
`ifdef MMIO_EN
    setv(0,  1, 9'h000, 16'h0101, 16'h0000, 0, 8'h00);
    setv(1,  1, 9'h040, 16'h4444, 16'h0000, 0, 8'h00);
    setv(2,  1, 9'h005, 16'h1234, 16'h0000, 0, 8'h00);
    setv(3,  0, 9'h005, 16'h0000, 16'h1234, 0, 8'h00);
    setv(4,  1, 9'h100, 16'h00A5, 16'h1234, 0, 8'hA5);
    setv(5,  0, 9'h100, 16'h0000, 16'h00A5, 0, 8'hA5);
    setv(6,  0, 9'h140, 16'h0000, 16'h003C, 0, 8'hA5);
    setv(7,  1, 9'h140, 16'hFFFF, 16'h003C, 0, 8'hA5);
    setv(8,  1, 9'h0F0, 16'hBEEF, 16'h003C, 0, 8'hA5);
    setv(9,  0, 9'h1F0, 16'h0000, 16'h0000, 1, 8'hA5);
    setv(10, 1, 9'h1F0, 16'h1111, 16'h0000, 1, 8'hA5);
    setv(11, 0, 9'h0F0, 16'h0000, 16'hBEEF, 0, 8'hA5);
    setv(12, 1, 9'h100, 16'h0077, 16'hBEEF, 0, 8'h77);
    setv(13, 0, 9'h000, 16'h0000, 16'h0101, 0, 8'h77);
    setv(14, 1, 9'h0FF, 16'hFFFF, 16'h0101, 0, 8'h77);
    setv(15, 0, 9'h0FF, 16'h0000, 16'hFFFF, 0, 8'h77);
`else
    setv(0,  1, 9'h000, 16'h0101, 16'h0000, 0, 8'h00);
    setv(1,  1, 9'h040, 16'h4444, 16'h0000, 0, 8'h00);
    setv(2,  1, 9'h005, 16'h1234, 16'h0000, 0, 8'h00);
    setv(3,  0, 9'h005, 16'h0000, 16'h1234, 0, 8'h00);
    setv(4,  1, 9'h100, 16'h00A5, 16'h1234, 0, 8'h00);
    setv(5,  0, 9'h100, 16'h0000, 16'h00A5, 0, 8'h00);
    setv(6,  0, 9'h140, 16'h0000, 16'h4444, 0, 8'h00);
    setv(7,  1, 9'h140, 16'hFFFF, 16'h4444, 0, 8'h00);
    setv(8,  1, 9'h0F0, 16'hBEEF, 16'h4444, 0, 8'h00);
    setv(9,  0, 9'h1F0, 16'h0000, 16'hBEEF, 0, 8'h00);
    setv(10, 1, 9'h1F0, 16'h1111, 16'hBEEF, 0, 8'h00);
    setv(11, 0, 9'h0F0, 16'h0000, 16'h1111, 0, 8'h00);
    setv(12, 1, 9'h100, 16'h0077, 16'h1111, 0, 8'h00);
    setv(13, 0, 9'h000, 16'h0000, 16'h0077, 0, 8'h00);
    setv(14, 1, 9'h0FF, 16'hFFFF, 16'h0077, 0, 8'h00);
    setv(15, 0, 9'h0FF, 16'h0000, 16'hFFFF, 0, 8'h00);
`endif

    for (int p = 0; p < 2; p++) begin
      sel = (p == 1);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ready", {31'h0, s_ready}, 32'd1);
      chk("reset_valid", {31'h0, s_valid}, 32'd0);
      chk("reset_rdata", {16'h0, s_rdata}, 32'd0);
      chk("reset_err", {31'h0, s_err}, 32'd0);
      chk("reset_led", {24'h0, s_led}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
        issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err, acc);
        drain();
        chk("ledr_out", {24'h0, s_led}, {24'h0, tbl[i].led});
      end

      // Request held valid continuously: accepts must be RD_LAT+1 apart.
      prev = -1;
      for (int k = 0; k < 4; k++) begin
        issue(1'b0, 9'h005, 16'h0000, 16'h1234, 1'b0, acc);
        if (k > 0) chk("accept_spacing", acc - prev, lat + 1);
        prev = acc;
      end
      drain();
    end

    // Asynchronous reset while the RD_LAT=4 instance is waiting on a write.
    sel = 1'b1;
    issue(1'b1, 9'h022, 16'h5A5A, 16'hFFFF, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'h0, s_ready}, 32'd1);
    chk("async_rst_valid", {31'h0, s_valid}, 32'd0);
    chk("async_rst_led", {24'h0, s_led}, 32'd0);
    chk("async_rst_rdata", {16'h0, s_rdata}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_valid) stray++;
    end
    chk("no_stale_rsp", stray, 0);
    issue(1'b0, 9'h022, 16'h0000, 16'h5A5A, 1'b0, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Absolute time limit in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
